// File: rtl/datamover_loopback_checker.sv
// datamover_loopback_checker
// Self-checking loopback tester for the AXI DataMover. A rising edge on
// i_start writes i_num_bursts bursts of a counting pattern through S2MM to
// consecutive DDR regions, checks each write status, reads each burst back
// through MM2S and compares it beat by beat.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_start                  level; rising edge launches a run
//   i_length                 bytes per burst
//   i_num_bursts             bursts per run (0 flags cfg_err)
//   i_start_addr             base byte address
//   *_s2mm_wr_cmd_*          S2MM command stream (out)
//   *_s2mm_wr_*              S2MM write data stream (out)
//   i_s2mm_sts_*             S2MM status stream (in, no ready)
//   *_mm2s_rd_cmd_*          MM2S command stream (out)
//   *_mm2s_rd_*              MM2S read data stream (in)
//   o_busy, o_done, o_pass   run status; o_done is a one-cycle pulse
//   o_err_cnt                saturating count of mismatched read beats
//   o_err_flags              {timeout, len_err, sts_err, cfg_err}
module datamover_loopback_checker #(
    parameter int unsigned DDR_ADDR_WIDTH = 40,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter logic [31:0] INIT_DATA      = 32'd0,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [15:0]                 i_length,
    input  logic [7:0]                  i_num_bursts,
    input  logic [DDR_ADDR_WIDTH-1:0]   i_start_addr,
    input  logic                        i_s2mm_wr_cmd_tready,
    output logic [DDR_ADDR_WIDTH+39:0]  o_s2mm_wr_cmd_tdata,
    output logic                        o_s2mm_wr_cmd_tvalid,
    output logic [DATA_WIDTH-1:0]       o_s2mm_wr_tdata,
    output logic [DATA_WIDTH/8-1:0]     o_s2mm_wr_tkeep,
    output logic                        o_s2mm_wr_tvalid,
    output logic                        o_s2mm_wr_tlast,
    input  logic                        i_s2mm_wr_tready,
    input  logic [7:0]                  i_s2mm_sts_tdata,
    input  logic                        i_s2mm_sts_tvalid,
    input  logic                        i_s2mm_sts_tlast,
    input  logic                        i_mm2s_rd_cmd_tready,
    output logic [DDR_ADDR_WIDTH+39:0]  o_mm2s_rd_cmd_tdata,
    output logic                        o_mm2s_rd_cmd_tvalid,
    input  logic [DATA_WIDTH-1:0]       i_mm2s_rd_tdata,
    input  logic [DATA_WIDTH/8-1:0]     i_mm2s_rd_tkeep,
    input  logic                        i_mm2s_rd_tvalid,
    input  logic                        i_mm2s_rd_tlast,
    output logic                        o_mm2s_rd_tready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_pass,
    output logic [31:0]                 o_err_cnt,
    output logic [3:0]                  o_err_flags
);

    localparam int unsigned BPB        = DATA_WIDTH / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BPB);
    localparam int unsigned CMD_WIDTH  = DDR_ADDR_WIDTH + 40;
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned TMO_WIDTH  = 24;
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_WR_STS,
        S_RD_CMD,
        S_RD_DATA,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                    state;
    logic                      start_q;
    logic                      start_pulse;
    logic [15:0]               len_q;
    logic [7:0]                nb_q;
    logic [15:0]               beats_q;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                burst_q;
    logic [31:0]               g_base;
    logic [15:0]               beat_idx;
    logic [TMO_WIDTH-1:0]      tmo_cnt;

    // DataMover command word, shared by S2MM and MM2S
    function automatic logic [CMD_WIDTH-1:0] make_cmd(
        input logic [3:0]                tag,
        input logic [DDR_ADDR_WIDTH-1:0] addr,
        input logic [15:0]               len
    );
        make_cmd = {4'd0, tag, addr, 1'b0, 1'b1, 6'd0, 1'b1, 7'd0, len};
    endfunction

    // Counting pattern for global beat index g, zero-extended
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] g);
        pattern = DATA_WIDTH'(INIT_DATA + g);
    endfunction

    logic [15:0]               beats_in;
    logic                      last_beat;
    logic [DDR_ADDR_WIDTH-1:0] addr_next;
    logic [7:0]                burst_next;
    logic                      rd_beat_bad;
    logic                      sts_bad;
    logic                      in_wait;
    logic                      advance;

    assign beats_in   = i_length >> BEAT_SHIFT;
    assign last_beat  = (beat_idx == beats_q - 16'd1);
    assign addr_next  = addr_q + DDR_ADDR_WIDTH'(len_q);
    assign burst_next = burst_q + 8'd1;
    // A partial beat cannot carry the full pattern word, so it counts as a mismatch
    assign rd_beat_bad = (i_mm2s_rd_tdata != pattern(g_base + 32'(beat_idx)))
                       || (i_mm2s_rd_tkeep != {KEEP_WIDTH{1'b1}});
    assign sts_bad    = !i_s2mm_sts_tdata[7] || (|i_s2mm_sts_tdata[6:4])
                      || (i_s2mm_sts_tdata[3:0] != burst_q[3:0]);
    assign in_wait    = (state == S_WR_CMD) || (state == S_WR_DATA) || (state == S_WR_STS)
                      || (state == S_RD_CMD) || (state == S_RD_DATA);

    // Condition that leaves the current wait state this cycle
    always_comb begin
        advance = 1'b0;
        unique case (state)
            S_WR_CMD:  advance = i_s2mm_wr_cmd_tready;
            S_WR_DATA: advance = i_s2mm_wr_tready && o_s2mm_wr_tlast;
            S_WR_STS:  advance = i_s2mm_sts_tvalid && i_s2mm_sts_tlast;
            S_RD_CMD:  advance = i_mm2s_rd_cmd_tready;
            S_RD_DATA: advance = i_mm2s_rd_tvalid && (i_mm2s_rd_tlast || last_beat);
            default:   advance = 1'b0;
        endcase
    end

    // Run sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= S_IDLE;
            start_q              <= 1'b0;
            start_pulse          <= 1'b0;
            len_q                <= '0;
            nb_q                 <= '0;
            beats_q              <= '0;
            addr_q               <= '0;
            burst_q              <= '0;
            g_base               <= '0;
            beat_idx             <= '0;
            tmo_cnt              <= '0;
            o_s2mm_wr_cmd_tdata  <= '0;
            o_s2mm_wr_cmd_tvalid <= 1'b0;
            o_s2mm_wr_tdata      <= '0;
            o_s2mm_wr_tkeep      <= '0;
            o_s2mm_wr_tvalid     <= 1'b0;
            o_s2mm_wr_tlast      <= 1'b0;
            o_mm2s_rd_cmd_tdata  <= '0;
            o_mm2s_rd_cmd_tvalid <= 1'b0;
            o_mm2s_rd_tready     <= 1'b0;
            o_busy               <= 1'b0;
            o_done               <= 1'b0;
            o_pass               <= 1'b0;
            o_err_cnt            <= '0;
            o_err_flags          <= '0;
        end else begin
            start_q     <= i_start;
            start_pulse <= i_start & ~start_q;
            o_done      <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        len_q       <= i_length;
                        nb_q        <= i_num_bursts;
                        beats_q     <= beats_in;
                        addr_q      <= i_start_addr;
                        burst_q     <= '0;
                        g_base      <= '0;
                        o_busy      <= 1'b1;
                        o_pass      <= 1'b0;
                        o_err_cnt   <= '0;
                        if ((beats_in == 16'd0) || (i_num_bursts == 8'd0)) begin
                            o_err_flags <= 4'b0001;
                            o_done      <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            o_err_flags          <= 4'b0000;
                            o_s2mm_wr_cmd_tdata  <= make_cmd(4'd0, i_start_addr, i_length);
                            o_s2mm_wr_cmd_tvalid <= 1'b1;
                            state                <= S_WR_CMD;
                        end
                    end
                end
                S_WR_CMD: begin
                    if (i_s2mm_wr_cmd_tready) begin
                        o_s2mm_wr_cmd_tvalid <= 1'b0;
                        o_s2mm_wr_tvalid     <= 1'b1;
                        o_s2mm_wr_tdata      <= pattern(g_base);
                        o_s2mm_wr_tkeep      <= '1;
                        o_s2mm_wr_tlast      <= (beats_q == 16'd1);
                        beat_idx             <= '0;
                        state                <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (i_s2mm_wr_tready) begin
                        if (o_s2mm_wr_tlast) begin
                            o_s2mm_wr_tvalid <= 1'b0;
                            o_s2mm_wr_tlast  <= 1'b0;
                            o_s2mm_wr_tkeep  <= '0;
                            state            <= S_WR_STS;
                        end else begin
                            beat_idx        <= beat_idx + 16'd1;
                            o_s2mm_wr_tdata <= pattern(g_base + 32'(beat_idx) + 32'd1);
                            o_s2mm_wr_tlast <= (beat_idx + 16'd2 == beats_q);
                        end
                    end
                end
                S_WR_STS: begin
                    if (i_s2mm_sts_tvalid) begin
                        if (sts_bad) begin
                            o_err_flags[1] <= 1'b1;
                        end
                        if (i_s2mm_sts_tlast) begin
                            o_mm2s_rd_cmd_tdata  <= make_cmd(burst_q[3:0], addr_q, len_q);
                            o_mm2s_rd_cmd_tvalid <= 1'b1;
                            state                <= S_RD_CMD;
                        end
                    end
                end
                S_RD_CMD: begin
                    if (i_mm2s_rd_cmd_tready) begin
                        o_mm2s_rd_cmd_tvalid <= 1'b0;
                        o_mm2s_rd_tready     <= 1'b1;
                        beat_idx             <= '0;
                        state                <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    // tready is high throughout this state, so tvalid is a handshake
                    if (i_mm2s_rd_tvalid) begin
                        if (rd_beat_bad && (o_err_cnt != 32'hFFFF_FFFF)) begin
                            o_err_cnt <= o_err_cnt + 32'd1;
                        end
                        if (i_mm2s_rd_tlast != last_beat) begin
                            o_err_flags[2] <= 1'b1;
                        end
                        if (i_mm2s_rd_tlast || last_beat) begin
                            o_mm2s_rd_tready <= 1'b0;
                            state            <= S_NEXT;
                        end else begin
                            beat_idx <= beat_idx + 16'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if (burst_q == nb_q - 8'd1) begin
                        o_done <= 1'b1;
                        o_pass <= (o_err_cnt == 32'd0) && (o_err_flags == 4'd0);
                        state  <= S_DONE;
                    end else begin
                        burst_q              <= burst_next;
                        addr_q               <= addr_next;
                        g_base               <= g_base + 32'(beats_q);
                        o_s2mm_wr_cmd_tdata  <= make_cmd(burst_next[3:0], addr_next, len_q);
                        o_s2mm_wr_cmd_tvalid <= 1'b1;
                        state                <= S_WR_CMD;
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Per-state watchdog; restarts whenever the state changes
            if (in_wait && !advance) begin
                if (tmo_cnt == TMO_LAST) begin
                    o_err_flags[3]       <= 1'b1;
                    o_s2mm_wr_cmd_tvalid <= 1'b0;
                    o_s2mm_wr_tvalid     <= 1'b0;
                    o_s2mm_wr_tlast      <= 1'b0;
                    o_s2mm_wr_tkeep      <= '0;
                    o_mm2s_rd_cmd_tvalid <= 1'b0;
                    o_mm2s_rd_tready     <= 1'b0;
                    o_done               <= 1'b1;
                    o_pass               <= 1'b0;
                    tmo_cnt              <= '0;
                    state                <= S_DONE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule
